// File: rtl/config_loader_pkg.sv
// rtl/config_loader_pkg.sv - shared defaults, index width and FSM states for the configuration loader
package config_loader_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_WORDS = 42;
  localparam int IDX_W         = $clog2(DEF_NUM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  // Wide enough to hold the larger of the setup/hold reload values.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/cfg_delay_counter.sv
// rtl/cfg_delay_counter.sv - loadable down-counter with zero flag, shared by the setup and hold phases
module cfg_delay_counter
  import config_loader_pkg::*;
#(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - sequences configuration words onto the latch bank data bus with framed one-hot enables
module config_loader
  import config_loader_pkg::*;
#(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int NUM_WORDS    = DEF_NUM_WORDS,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  localparam int IW          = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_abort,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_bits,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic [IW-1:0]        io_word_idx
);

  localparam int              CNT_W      = cnt_width(SETUP_CYCLES, HOLD_CYCLES);
  localparam logic [IW-1:0]   LAST_IDX   = IW'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

  state_t                state, state_nxt;
  logic [IW-1:0]         idx;
  logic                  idx_clr, idx_inc;
  logic                  accept;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]      cnt_load_val;
  logic [NUM_WORDS-1:0]  en_nxt;

  cfg_delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_clr      = 1'b0;
    idx_inc      = 1'b0;
    accept       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = SETUP_LOAD;
    cnt_dec      = 1'b0;
    // Abort outranks everything, including a simultaneous start in IDLE.
    if (io_abort) begin
      state_nxt = IDLE;
      idx_clr   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (io_start) begin
            state_nxt = ACCEPT;
            idx_clr   = 1'b1;
          end
        end
        ACCEPT: begin
          if (io_in_valid) begin
            accept       = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = SETUP_LOAD;
            state_nxt    = SETUP;
          end
        end
        SETUP: begin
          if (cnt_zero) state_nxt = STROBE;
          else          cnt_dec   = 1'b1;
        end
        STROBE: begin
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LOAD;
          state_nxt    = HOLD;
        end
        HOLD: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = ACCEPT;
          end
        end
        DONE: begin
          idx_clr   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Enables are decoded one cycle early so the latch bank sees them straight from flops.
  always_comb begin
    en_nxt = '0;
    if (state_nxt == STROBE) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        en_nxt[i] = (idx == IW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx           <= '0;
      io_d_out      <= '0;
      io_configs_en <= '0;
    end else begin
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + IW'(1);
      end
      if (accept) begin
        io_d_out <= io_in_bits;
      end
      io_configs_en <= en_nxt;
    end
  end

  assign io_in_ready = (state == ACCEPT);
  assign io_busy     = (state != IDLE);
  assign io_done     = (state == DONE);
  assign io_word_idx = idx;

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - randomized self-checking bench for config_loader with a schedule reference model
module tb_config_loader;

  localparam int NW = 42;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        start, abort, valid, ready, busy, done;
  logic [31:0]       bits [2];
  logic [31:0]       dout [2];
  logic [NW-1:0]     en   [2];
  logic [5:0]        widx [2];

  int          n_checks = 0;
  int          n_errors = 0;
  bit          fin;
  logic [31:0] word_tab [NW];
  int          stall_tab [NW];
  int          s_idx [64];
  logic [31:0] s_dat [64];
  int          s_rel [64];
  int          n_strobe, n_done, done_rel, overlap, bad_window;

  always #5 clk = ~clk;

  config_loader dut0 (
    .clk(clk), .reset(rst_n), .io_start(start[0]), .io_abort(abort[0]),
    .io_in_valid(valid[0]), .io_in_ready(ready[0]), .io_in_bits(bits[0]),
    .io_d_out(dout[0]), .io_configs_en(en[0]), .io_busy(busy[0]),
    .io_done(done[0]), .io_word_idx(widx[0])
  );

  config_loader #(.SETUP_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
    .clk(clk), .reset(rst_n), .io_start(start[1]), .io_abort(abort[1]),
    .io_in_valid(valid[1]), .io_in_ready(ready[1]), .io_in_bits(bits[1]),
    .io_d_out(dout[1]), .io_configs_en(en[1]), .io_busy(busy[1]),
    .io_done(done[1]), .io_word_idx(widx[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int g, input logic [31:0] exp_d);
    check_eq({tag, "_en"},    64'(en[g]),   64'd0);
    check_eq({tag, "_dout"},  64'(dout[g]), 64'(exp_d));
    check_eq({tag, "_ready"}, 64'(ready[g]), 64'd0);
    check_eq({tag, "_busy"},  64'(busy[g]), 64'd0);
    check_eq({tag, "_done"},  64'(done[g]), 64'd0);
    check_eq({tag, "_idx"},   64'(widx[g]), 64'd0);
  endtask

  task automatic fill_tables(input bit fixed_words, input int max_stall);
    for (int i = 0; i < NW; i++) begin
      word_tab[i]  = fixed_words ? (32'hA500_0000 + 32'(i)) : $urandom;
      stall_tab[i] = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
    end
  endtask

  // Upstream source: presents word i once the loader is ready, after stall_tab[i] idle cycles.
  task automatic drive(input int g);
    int t;
    for (int i = 0; i < NW; i++) begin
      t = 0;
      @(negedge clk);
      while (!ready[g] && !fin && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (fin || !ready[g]) return;
      repeat (stall_tab[i]) @(negedge clk);
      bits[g]  = word_tab[i];
      valid[g] = 1'b1;
      @(negedge clk);
      valid[g] = 1'b0;
    end
  endtask

  task automatic monitor(input int g, input int sc, input int hc, input int abort_at,
                         input int reset_at, input int reset_delay, input bit spam);
    int          rel = 0;
    int          last_change = -100;
    int          hold_until = -1;
    int          rst_cnt = -1;
    int          k;
    bit          abort_pend = 1'b0;
    logic [31:0] prev_d;
    prev_d = dout[g];
    n_strobe = 0; n_done = 0; done_rel = -1; overlap = 0; bad_window = 0;
    while (!fin) begin
      @(negedge clk);
      if (abort_pend) begin
        check_idle_outputs($sformatf("g%0d_abort", g), g, word_tab[abort_at]);
        abort[g] = 1'b0;
        fin = 1'b1;
      end else begin
        if (dout[g] !== prev_d) begin
          last_change = rel;
          if (rel <= hold_until) bad_window++;
          prev_d = dout[g];
        end
        if (rel == 0) begin
          check_eq($sformatf("g%0d_start_ready", g), 64'(ready[g]), 64'd1);
          check_eq($sformatf("g%0d_start_idx", g), 64'(widx[g]), 64'd0);
        end
        if (en[g] != '0) begin
          if ($countones(en[g]) != 1) overlap++;
          k = 0;
          for (int b = 0; b < NW; b++) if (en[g][b]) k = b;
          if (n_strobe < 64) begin
            s_idx[n_strobe] = k;
            s_dat[n_strobe] = dout[g];
            s_rel[n_strobe] = rel;
          end
          n_strobe++;
          if (last_change > rel - sc) bad_window++;
          hold_until = rel + hc;
          if (k == abort_at) begin
            abort[g]   = 1'b1;
            abort_pend = 1'b1;
          end
          if (k == reset_at) rst_cnt = reset_delay;
        end
        if (done[g]) begin
          n_done++;
          if (done_rel < 0) done_rel = rel;
        end
        if (rst_cnt == 0) begin
          rst_n = 1'b0;
          #1;
          check_idle_outputs($sformatf("g%0d_async_rst", g), g, 32'd0);
          fin = 1'b1;
        end else if (rst_cnt > 0) begin
          rst_cnt--;
        end
        if ((done_rel >= 0 && rel > done_rel) || rel > 1500) fin = 1'b1;
        start[g] = (spam && done_rel < 0 && !fin) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      rel++;
    end
  endtask

  // Reference schedule: word i becomes acceptable at r, is taken 1+stall cycles later,
  // strobes SETUP cycles after that, and the next word is acceptable HOLD+1 cycles after the strobe.
  task automatic run_load(input int g, input int abort_at, input int reset_at,
                          input int reset_delay, input bit spam);
    int sc, hc, r, a, n_exp;
    int exp_rel [NW];
    sc = (g == 1) ? 3 : 1;
    hc = (g == 1) ? 2 : 1;
    r  = 0;
    for (int i = 0; i < NW; i++) begin
      a          = r + 1 + stall_tab[i];
      exp_rel[i] = a + sc;
      r          = a + sc + hc + 1;
    end
    n_exp = (abort_at >= 0) ? abort_at + 1 : (reset_at >= 0) ? reset_at + 1 : NW;
    fin = 1'b0;
    @(negedge clk);
    start[g] = 1'b1;
    fork
      drive(g);
      monitor(g, sc, hc, abort_at, reset_at, reset_delay, spam);
    join
    start[g] = 1'b0;
    valid[g] = 1'b0;
    abort[g] = 1'b0;
    check_eq($sformatf("g%0d_strobes", g), 64'(n_strobe), 64'(n_exp));
    for (int j = 0; j < n_exp && j < n_strobe && j < 64; j++) begin
      check_eq($sformatf("g%0d_w%0d_idx", g, j),  64'(s_idx[j]), 64'(j));
      check_eq($sformatf("g%0d_w%0d_data", g, j), 64'(s_dat[j]), 64'(word_tab[j]));
      check_eq($sformatf("g%0d_w%0d_time", g, j), 64'(s_rel[j]), 64'(exp_rel[j]));
    end
    check_eq($sformatf("g%0d_overlap", g), 64'(overlap), 64'd0);
    check_eq($sformatf("g%0d_dout_window", g), 64'(bad_window), 64'd0);
    if (n_exp == NW) begin
      check_eq($sformatf("g%0d_done_count", g), 64'(n_done), 64'd1);
      check_eq($sformatf("g%0d_done_time", g), 64'(done_rel), 64'(r));
      check_idle_outputs($sformatf("g%0d_after_done", g), g, word_tab[NW-1]);
    end else begin
      check_eq($sformatf("g%0d_no_done", g), 64'(n_done), 64'd0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = '0;
    abort   = '0;
    valid   = '0;
    bits[0] = '0;
    bits[1] = '0;
    fin     = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) check_idle_outputs($sformatf("g%0d_reset", g), g, 32'd0);
    rst_n = 1'b1;

    fill_tables(1'b0, 0);
    run_load(0, 10, -1, 0, 1'b0);

    fill_tables(1'b1, 0);
    run_load(0, -1, -1, 0, 1'b0);
    check_eq("g0_done_at_168", 64'(done_rel), 64'd168);

    @(negedge clk);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    check_eq("idle_abort_wins_busy", 64'(busy[0]), 64'd0);
    check_eq("idle_abort_wins_ready", 64'(ready[0]), 64'd0);
    start[0] = 1'b0;
    abort[0] = 1'b0;

    fill_tables(1'b0, 0);
    stall_tab[7] = 5;
    run_load(0, -1, -1, 0, 1'b1);
    check_eq("g0_backpressure_w7", 64'(s_rel[7]), 64'd35);

    fill_tables(1'b0, 0);
    run_load(0, -1, 20, 1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    fill_tables(1'b0, 3);
    run_load(0, -1, -1, 0, 1'b0);

    fill_tables(1'b0, 0);
    run_load(1, -1, -1, 0, 1'b0);
    check_eq("g1_word_pitch", 64'(s_rel[1] - s_rel[0]), 64'd7);

    fill_tables(1'b0, 4);
    run_load(1, -1, -1, 0, 1'b1);

    fill_tables(1'b0, 2);
    run_load(1, -1, 5, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    fill_tables(1'b0, 1);
    run_load(1, -1, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
